clock_period_meter: RTL and testbench

- Measures the half-period of an incoming toggling signal in clk_in cycles and reports it in divisor units, so a measured value feeds straight back into the divider's divisor input.
- Counterpart of the divider: the divider turns a divisor into a clock; this block recovers the divisor from that clock.
- Sits on control/debug paths.
- Intended uses: verifying divider output, locking to external DSP frame clocks, detecting a dead clock.

---
 rtl/dsp_ctrl_pkg.sv | 23 ++
 rtl/sync_edge_detect.sv | 36 +++
 rtl/clock_period_meter.sv | 169 ++++++++++++++++
 tb/tb_clock_period_meter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the clock period meter and related control blocks.
//   state_t : measurement FSM state, 1-bit encoding
//   dbg_t   : debug snapshot of the meter's internal state
//   DEFAULT_WIDTH : default counter/result width
//   LOCK_CNT_W    : width of the consecutive-match counter (LOCK_COUNT <= 15)
package dsp_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int LOCK_CNT_W    = 4;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } state_t;

   typedef struct packed {
      state_t                 state;
      logic                   level;      // synchronized sig_in level
      logic                   have_prev;  // a reference measurement exists
      logic [LOCK_CNT_W-1:0]  match_cnt;
   } dbg_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous input into the clk_in domain and flags every
// transition (rising or falling) as a one-cycle pulse.
//   clk_in   : clock, rising edge
//   rst      : synchronous active-high reset, clears the chain to 0
//   async_in : asynchronous input
//   edge_out : high for one cycle after each transition of the synced level
//              ("edge" itself is a reserved word)
//   level    : synchronized level (last synchronizer stage)
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst,
   input  logic async_in,
   output logic edge_out,
   output logic level
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_dly;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_sync <= '0;
         r_dly  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
         r_dly  <= r_sync[SYNC_STAGES-1];
      end
   end

   // Edge = last sync stage differs from its one-cycle-delayed copy.
   assign edge_out = r_sync[SYNC_STAGES-1] ^ r_dly;
   assign level    = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/clock_period_meter.sv
// Measures the half-period of a toggling signal in clk_in cycles and reports
// it in divisor units (edges D+1 cycles apart report D), so the result can be
// fed straight back into a clock divider's divisor input.
//   clk_in      : system clock, rising edge
//   rst         : synchronous active-high reset
//   sig_in      : signal to measure, asynchronous to clk_in
//   divisor_out : last measured half-period, held between measurements
//   meas_valid  : one-cycle strobe when divisor_out updates; there is no
//                 back-pressure, a consumer must take the value on the strobe
//   locked      : LOCK_COUNT consecutive measurements within TOLERANCE
//   timeout     : no edge for MAX_COUNT cycles; sticky until next edge/reset
//   dbg         : FSM state and lock bookkeeping for observation
module clock_period_meter
   import dsp_ctrl_pkg::*;
#(
   parameter int               WIDTH       = DEFAULT_WIDTH,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(32'hFFFF_FFFE),
   parameter int               LOCK_COUNT  = 4,
   parameter int               TOLERANCE   = 1
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sig_in,
   output logic [WIDTH-1:0] divisor_out,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout,
   output dbg_t             dbg
);

   localparam logic [LOCK_CNT_W-1:0] LP_LOCK    = LOCK_CNT_W'(LOCK_COUNT);
   localparam logic [LOCK_CNT_W-1:0] LP_LOCK_M1 = LOCK_CNT_W'(LOCK_COUNT - 1);
   localparam logic [WIDTH:0]        LP_TOL     = (WIDTH+1)'(TOLERANCE);

   logic w_edge;
   logic w_level;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_in   (clk_in),
      .rst      (rst),
      .async_in (sig_in),
      .edge_out (w_edge),
      .level    (w_level)
   );

   state_t                r_state,     w_state_next;
   logic [WIDTH-1:0]      r_cnt,       w_cnt_next;
   logic [WIDTH-1:0]      r_div,       w_div_next;
   logic [WIDTH-1:0]      r_prev,      w_prev_next;
   logic                  r_meas,      w_meas_next;
   logic                  r_locked,    w_locked_next;
   logic                  r_timeout,   w_timeout_next;
   logic                  r_have_prev, w_have_prev_next;
   logic [LOCK_CNT_W-1:0] r_match,     w_match_next;

   // Difference taken one bit wider than the operands so that a smaller
   // current count cannot wrap into a huge positive value.
   logic [WIDTH:0] w_diff_raw;
   logic [WIDTH:0] w_diff_abs;
   logic           w_match;

   assign w_diff_raw = {1'b0, r_cnt} - {1'b0, r_prev};
   assign w_diff_abs = w_diff_raw[WIDTH] ? ((~w_diff_raw) + (WIDTH+1)'(1))
                                         : w_diff_raw;
   assign w_match    = (w_diff_abs <= LP_TOL);

   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_div       <= '0;
         r_prev      <= '0;
         r_meas      <= 1'b0;
         r_locked    <= 1'b0;
         r_timeout   <= 1'b0;
         r_have_prev <= 1'b0;
         r_match     <= '0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_div       <= w_div_next;
         r_prev      <= w_prev_next;
         r_meas      <= w_meas_next;
         r_locked    <= w_locked_next;
         r_timeout   <= w_timeout_next;
         r_have_prev <= w_have_prev_next;
         r_match     <= w_match_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_div_next       = r_div;
      w_prev_next      = r_prev;
      w_meas_next      = 1'b0;
      w_locked_next    = r_locked;
      w_timeout_next   = r_timeout;
      w_have_prev_next = r_have_prev;
      w_match_next     = r_match;

      // Interval counter: restarts on every edge, saturates otherwise.
      if (w_edge) begin
         w_cnt_next = '0;
      end else if (r_cnt >= MAX_COUNT) begin
         w_cnt_next = MAX_COUNT;
      end else begin
         w_cnt_next = r_cnt + WIDTH'(1);
      end

      case (r_state)
         ST_IDLE: begin
            // First edge only starts timing: the interval before it is partial.
            if (w_edge) begin
               w_state_next     = ST_MEASURE;
               w_timeout_next   = 1'b0;
               w_have_prev_next = 1'b0;
            end
         end

         ST_MEASURE: begin
            // An edge in the same cycle the counter saturates takes priority.
            if (w_edge) begin
               w_div_next       = r_cnt;
               w_meas_next      = 1'b1;
               w_prev_next      = r_cnt;
               w_have_prev_next = 1'b1;
               if (r_have_prev) begin
                  if (w_match) begin
                     if (r_match < LP_LOCK) begin
                        w_match_next = r_match + LOCK_CNT_W'(1);
                     end
                     // LOCK_COUNT-1 earlier matches plus this one.
                     if (r_match >= LP_LOCK_M1) begin
                        w_locked_next = 1'b1;
                     end
                  end else begin
                     w_match_next  = '0;
                     w_locked_next = 1'b0;
                  end
               end
            end else if (r_cnt == MAX_COUNT) begin
               w_timeout_next   = 1'b1;
               w_locked_next    = 1'b0;
               w_match_next     = '0;
               w_have_prev_next = 1'b0;
               w_state_next     = ST_IDLE;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign divisor_out   = r_div;
   assign meas_valid    = r_meas;
   assign locked        = r_locked;
   assign timeout       = r_timeout;

   assign dbg.state     = r_state;
   assign dbg.level     = w_level;
   assign dbg.have_prev = r_have_prev;
   assign dbg.match_cnt = r_match;

endmodule

// File: tb/tb_clock_period_meter.sv
module tb_clock_period_meter;
  import dsp_ctrl_pkg::*;

  localparam int WIDTH = 32;
  localparam int MAXC  = 100;
  localparam int LOCKN = 4;
  localparam int TOL   = 1;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sig_in = 1'b0;
  logic [WIDTH-1:0] divisor_out;
  logic             meas_valid;
  logic             locked;
  logic             timeout;
  dbg_t             dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  clock_period_meter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2),
    .MAX_COUNT   (WIDTH'(MAXC)),
    .LOCK_COUNT  (LOCKN),
    .TOLERANCE   (TOL)
  ) dut (
    .clk_in      (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .divisor_out (divisor_out),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .timeout     (timeout),
    .dbg         (dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Each entry: {locked, divisor}
  logic [WIDTH:0] exp_q[$];

  bit m_measure   = 1'b0;
  bit m_have_prev = 1'b0;
  int m_prev      = 0;
  int m_match     = 0;
  bit m_locked    = 1'b0;
  int m_last_div  = 0;
  int last_cyc    = 0;

  // Account for an edge arriving gap cycles after the previous one.
  task automatic model_edge(input int gap);
    int d;
    int diff;
    d = gap - 1;
    if (m_measure && (d > MAXC)) begin
      // counter hit MAXC with no edge: timeout dropped the meter to idle
      m_measure   = 1'b0;
      m_have_prev = 1'b0;
      m_match     = 0;
      m_locked    = 1'b0;
    end
    if (!m_measure) begin
      m_measure = 1'b1;
    end else begin
      if (m_have_prev) begin
        diff = (d > m_prev) ? d - m_prev : m_prev - d;
        if (diff <= TOL) begin
          if (m_match < LOCKN) m_match++;
          if (m_match >= LOCKN) m_locked = 1'b1;
        end else begin
          m_match  = 0;
          m_locked = 1'b0;
        end
      end
      m_have_prev = 1'b1;
      m_prev      = d;
      m_last_div  = d;
      exp_q.push_back({m_locked, WIDTH'(d)});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Toggle sig_in at least n cycles after the previous toggle.
  task automatic drive_gap(input int n);
    @(posedge clk); #1;
    while (cyc - last_cyc < n) begin
      @(posedge clk); #1;
    end
    model_edge(cyc - last_cyc);
    sig_in   = ~sig_in;
    last_cyc = cyc;
  endtask

  task automatic drive_run(input int gap, input int count);
    for (int i = 0; i < count; i++) drive_gap(gap);
  endtask

  task automatic drive_alt(input int gap_a, input int gap_b, input int pairs);
    for (int i = 0; i < pairs; i++) begin
      drive_gap(gap_a);
      drive_gap(gap_b);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_div"},     64'(divisor_out), 64'd0);
    check({tag, "_valid"},   64'(meas_valid),  64'd0);
    check({tag, "_locked"},  64'(locked),      64'd0);
    check({tag, "_timeout"}, 64'(timeout),     64'd0);
    check({tag, "_state"},   64'(dbg.state),   64'(ST_IDLE));
  endtask

  // One-cycle reset pulse; sig_in parked low so release creates no edge.
  task automatic pulse_reset();
    @(posedge clk); #1;
    rst    = 1'b1;
    sig_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_measure   = 1'b0;
    m_have_prev = 1'b0;
    m_match     = 0;
    m_locked    = 1'b0;
    m_last_div  = 0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && meas_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_meas_valid", 64'(meas_valid), 64'd0);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        check("divisor_out", 64'(divisor_out), 64'(e[WIDTH-1:0]));
        check("locked",      64'(locked),      64'(e[WIDTH]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst = 1'b1;
    wait_cycles(3);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // divider with divisor 4: lock on the 5th strobe
    drive_run(5, 9);
    // divisor change 4 -> 9: unlock on the first 9, relock after 4 more
    drive_run(10, 7);
    // divisor 0: toggle every cycle
    drive_run(1, 8);
    // jitter 7/8 within tolerance: locks
    drive_alt(8, 9, 5);
    // jitter 7/9 outside tolerance: never stays locked
    drive_alt(8, 10, 5);
    // boundary: edge in the same cycle the counter reaches MAXC
    drive_run(101, 2);
    wait_cycles(4);
    @(negedge clk);
    check("edge_wins_no_timeout", 64'(timeout), 64'd0);

    // lock again at divisor 4, then hold sig_in to force a timeout
    drive_run(5, 6);
    k = 0;
    while (timeout !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("timeout_rise",      64'(timeout),     64'd1);
    check("timeout_locked",    64'(locked),      64'd0);
    check("timeout_div_held",  64'(divisor_out), 64'(m_last_div));
    check("timeout_state",     64'(dbg.state),   64'(ST_IDLE));
    wait_cycles(10);
    @(negedge clk);
    check("timeout_sticky",    64'(timeout),     64'd1);
    // next edge clears timeout without a strobe
    drive_gap(1);
    wait_cycles(5);
    @(negedge clk);
    check("timeout_cleared",   64'(timeout),     64'd0);
    check("timeout_div_still", 64'(divisor_out), 64'(m_last_div));
    // edge after that measures again; relock
    drive_run(5, 6);

    // reset mid-interval while locked
    wait_cycles(6);
    @(negedge clk);
    check("pre_reset_locked", 64'(locked), 64'd1);
    pulse_reset();
    check_reset_outputs("midreset");
    drive_run(5, 4);

    wait_cycles(10);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global guard so a stuck run still terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

endmodule
